taus88_multi: RTL and testbench
===============================

// Module: taus88_multi
// PURPOSE
//   Parametrised successor to the single-lane Taus88 RNG. NUM_LANES independent
//   Taus88 generators are seeded from one 32-bit seed by an internal seeding FSM
//   with per-lane salt decorrelation, followed by an optional warm-up discard.
//   The generators drive a valid/ready output so stochastic-compute consumers can
//   stall them. Drop-in wide random source for stochsuite datapaths.
// PARAMETERS
//   NUM_LANES     4             number of Taus88 lanes, 1..16
//   WARMUP        8             steps discarded after seeding, 0..255
//   DEFAULT_SEED  32'h1234_5678 seed applied on reset
// PORTS
//   clk       in   1             single clock, rising edge
//   rst       in   1             synchronous, active-high reset
//   seed      in   32            seed word, sampled only when reseed=1
//   reseed    in   1             one-cycle request: restart seeding with seed
//   out_data  out  NUM_LANES*32  lane l occupies bits [32*l+31:32*l]
//   out_valid out  1             out_data holds a fresh, unconsumed word set
//   out_ready in   1             consumer accepts out_data when out_valid=1
//   busy      out  1             1 in any state other than RUN
// BEHAVIOUR
// - FSM states: SEED -> PRIME -> WARM -> RUN.
//   - rst=1: state=SEED, lane_idx=0, latched seed=DEFAULT_SEED,
//     out_valid=0, out_data=0, busy=1. All lane state is don't-care until seeded.
// - SEED: one lane per cycle, l = 0..NUM_LANES-1 (NUM_LANES cycles).
//   - Per-lane salts: s1 = sd ^ (l*32'h9E3779B9), s2 = sd ^ (l*32'h85EBCA6B),
//     s3 = sd ^ (l*32'hC2B2AE35), all mod 2^32.
//   - Salts come from accumulators (add the constant each cycle); no multipliers.
//   - Fix-up: if s1<2 then s1^=2; if s2<8 then s2^=8; if s3<16 then s3^=16.
// - Taus88 step, per lane, on 32-bit arithmetic with truncation:
//   - s1' = ((s1&~1)<<12) ^ (((s1<<13)^s1)>>19)
//   - s2' = ((s2&~7)<<4) ^ (((s2<<2)^s2)>>25)
//   - s3' = ((s3&~15)<<17) ^ (((s3<<3)^s3)>>11)
//   - word = s1'^s2'^s3'
// - PRIME: one cycle, one step; word is registered into out_data. Next state is
//   WARM if WARMUP>0, else RUN.
// - WARM: one step per cycle for WARMUP cycles. out_data is overwritten each
//   cycle; out_valid stays 0.
// - RUN: out_valid=1. A step occurs only on out_valid&out_ready, which loads the
//   next word the following cycle with out_valid kept at 1. If out_ready=0,
//   out_data and lane state hold exactly.
// - Latency: from rst deassert (or reseed) to out_valid=1 is NUM_LANES+1+WARMUP
//   cycles.
// - reseed=1 in any state (including SEED/WARM) latches seed and enters SEED with
//   lane_idx=0. out_valid=0 from the next cycle.
// - reseed and out_ready both 1 in the same cycle: reseed wins. That handshake is
//   void; the consumer must not count the word.
// - rst has priority over reseed.
// - busy = (state != RUN), registered with the state.
// TESTING
//   1. NUM_LANES=4, WARMUP=0, DEFAULT_SEED=0, out_ready=1, pulse rst ->
//      out_valid rises exactly 5 cycles after rst falls; lane0 gives 32'h00202080,
//      then 32'h02002C80.
//   2. Hold out_ready=0 for 10 cycles in RUN -> out_data and out_valid stable;
//      on release, the next word equals the C model's next step (no skipped or
//      repeated words).
//   3. Mid-RUN reseed with seed=0 -> out_valid=0 next cycle, busy=1 for 5 cycles;
//      lane0 restarts at 32'h00202080.
//   4. seed=32'hDEADBEEF, NUM_LANES=16 -> all lanes match the software model with
//      salts over 1000 words; no two lanes are equal on any word.
//   5. reseed during SEED (lane_idx=2) and reseed together with a handshake ->
//      FSM restarts; the voided word is not followed by a model step.
//   6. WARMUP=8, seed=0 -> first valid lane0 word equals the model's 9th step;
//      out_valid first rises NUM_LANES+9 cycles after reseed.

Source files
------------

// File: rtl/taus88_multi.sv
// Multi-lane Taus88 random source: a seeding FSM fills NUM_LANES generators with
// salted copies of one seed, discards WARMUP steps, then streams words over valid/ready.
module taus88_multi #(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned WARMUP       = 8,
    parameter logic [31:0] DEFAULT_SEED = 32'h1234_5678
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             seed,
    input  logic                    reseed,
    output logic [NUM_LANES*32-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam logic [31:0] K1 = 32'h9E37_79B9;
    localparam logic [31:0] K2 = 32'h85EB_CA6B;
    localparam logic [31:0] K3 = 32'hC2B2_AE35;

    typedef enum logic [1:0] {SEED, PRIME, WARM, RUN} state_e;

    state_e                  state_q;
    logic [4:0]              lane_idx_q;
    logic [7:0]              warm_q;
    logic [31:0]             seed_q;
    logic [31:0]             acc1_q, acc2_q, acc3_q;
    logic [31:0]             s1_q [NUM_LANES];
    logic [31:0]             s2_q [NUM_LANES];
    logic [31:0]             s3_q [NUM_LANES];
    logic [31:0]             s1_d [NUM_LANES];
    logic [31:0]             s2_d [NUM_LANES];
    logic [31:0]             s3_d [NUM_LANES];
    logic [NUM_LANES*32-1:0] word_d;
    logic [NUM_LANES*32-1:0] data_q;
    logic                    valid_q;
    logic                    busy_q;
    logic [31:0]             salt1_d, salt2_d, salt3_d;
    logic                    step_en;

    function automatic logic [31:0] step1(input logic [31:0] s);
        return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction

    function automatic logic [31:0] step2(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction

    function automatic logic [31:0] step3(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    always_comb begin
        s1_d   = '{default: '0};
        s2_d   = '{default: '0};
        s3_d   = '{default: '0};
        word_d = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            s1_d[l] = step1(s1_q[l]);
            s2_d[l] = step2(s2_q[l]);
            s3_d[l] = step3(s3_q[l]);
            word_d[32*l +: 32] = s1_d[l] ^ s2_d[l] ^ s3_d[l];
        end
        // Accumulators hold lane_idx*K, so the salt needs no multiplier.
        salt1_d = seed_q ^ acc1_q;
        salt2_d = seed_q ^ acc2_q;
        salt3_d = seed_q ^ acc3_q;
        if (salt1_d < 32'd2)  salt1_d = salt1_d ^ 32'd2;
        if (salt2_d < 32'd8)  salt2_d = salt2_d ^ 32'd8;
        if (salt3_d < 32'd16) salt3_d = salt3_d ^ 32'd16;
        step_en = (state_q == PRIME) || (state_q == WARM) || ((state_q == RUN) && out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEED;
            lane_idx_q <= '0;
            warm_q     <= '0;
            seed_q     <= DEFAULT_SEED;
            acc1_q     <= '0;
            acc2_q     <= '0;
            acc3_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else if (reseed) begin
            state_q    <= SEED;
            lane_idx_q <= '0;
            warm_q     <= '0;
            seed_q     <= seed;
            acc1_q     <= '0;
            acc2_q     <= '0;
            acc3_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            if (step_en) begin
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    s1_q[l] <= s1_d[l];
                    s2_q[l] <= s2_d[l];
                    s3_q[l] <= s3_d[l];
                end
                data_q <= word_d;
            end
            case (state_q)
                SEED: begin
                    for (int unsigned l = 0; l < NUM_LANES; l++) begin
                        if (lane_idx_q == 5'(l)) begin
                            s1_q[l] <= salt1_d;
                            s2_q[l] <= salt2_d;
                            s3_q[l] <= salt3_d;
                        end
                    end
                    acc1_q     <= acc1_q + K1;
                    acc2_q     <= acc2_q + K2;
                    acc3_q     <= acc3_q + K3;
                    lane_idx_q <= lane_idx_q + 5'd1;
                    if (lane_idx_q == 5'(NUM_LANES - 1)) state_q <= PRIME;
                end
                PRIME: begin
                    warm_q <= '0;
                    if (WARMUP > 0) begin
                        state_q <= WARM;
                    end else begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                WARM: begin
                    warm_q <= warm_q + 8'd1;
                    if (warm_q == 8'(WARMUP - 1)) begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: ;
                default: state_q <= SEED;
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_taus88_multi.sv
// Bench for taus88_multi: two configurations checked every cycle against a
// cycle-counting behavioural model, plus directed latency/value expectations.
module tb_taus88_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstA, reseedA, rdyA, validA, busyA;
    logic [31:0]  seedA;
    logic [127:0] dataA;
    logic         rstB, reseedB, rdyB, validB, busyB;
    logic [31:0]  seedB;
    logic [511:0] dataB;

    taus88_multi #(.NUM_LANES(4), .WARMUP(0), .DEFAULT_SEED(32'h0)) dutA (
        .clk(clk), .rst(rstA), .seed(seedA), .reseed(reseedA),
        .out_data(dataA), .out_valid(validA), .out_ready(rdyA), .busy(busyA)
    );

    taus88_multi #(.NUM_LANES(16), .WARMUP(8), .DEFAULT_SEED(32'hDEAD_BEEF)) dutB (
        .clk(clk), .rst(rstB), .seed(seedB), .reseed(reseedB),
        .out_data(dataB), .out_valid(validB), .out_ready(rdyB), .busy(busyB)
    );

    int errors = 0;
    int checks = 0;

    // Model configuration per DUT (0 = A, 1 = B)
    int          nl   [2] = '{4, 16};
    int          wu   [2] = '{0, 8};
    logic [31:0] dflt [2] = '{32'h0, 32'hDEAD_BEEF};

    logic [31:0] ms1 [2][16];
    logic [31:0] ms2 [2][16];
    logic [31:0] ms3 [2][16];
    logic        mvalid   [2] = '{1'b0, 1'b0};
    logic        mstarted [2] = '{1'b0, 1'b0};
    logic [31:0] mseed    [2];
    int          mcnt     [2];
    bit          distinct_en = 1'b0;

    task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] t1(input logic [31:0] s);
        return ((s & ~32'd1) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction
    function automatic logic [31:0] t2(input logic [31:0] s);
        return ((s & ~32'd7) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction
    function automatic logic [31:0] t3(input logic [31:0] s);
        return ((s & ~32'd15) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    function automatic logic [31:0] mword(input int m, input int l);
        return ms1[m][l] ^ ms2[m][l] ^ ms3[m][l];
    endfunction

    task automatic mstep(input int m);
        for (int l = 0; l < nl[m]; l++) begin
            ms1[m][l] = t1(ms1[m][l]);
            ms2[m][l] = t2(ms2[m][l]);
            ms3[m][l] = t3(ms3[m][l]);
        end
    endtask

    task automatic mseedlanes(input int m);
        logic [31:0] a, b, c;
        for (int l = 0; l < nl[m]; l++) begin
            a = mseed[m] ^ (32'(l) * 32'h9E37_79B9);
            b = mseed[m] ^ (32'(l) * 32'h85EB_CA6B);
            c = mseed[m] ^ (32'(l) * 32'hC2B2_AE35);
            if (a < 2)  a = a ^ 32'd2;
            if (b < 8)  b = b ^ 32'd8;
            if (c < 16) c = c ^ 32'd16;
            ms1[m][l] = a;
            ms2[m][l] = b;
            ms3[m][l] = c;
        end
    endtask

    // Model: after (re)start, output appears N+1+W edges later as the (W+1)-th step
    task automatic medge(input int m, input logic r, input logic rs, input logic [31:0] sd, input logic rdy);
        if (r) begin
            mstarted[m] = 1'b1;
            mvalid[m]   = 1'b0;
            mseed[m]    = dflt[m];
            mcnt[m]     = 0;
        end else if (!mstarted[m]) begin
            mcnt[m] = 0;
        end else if (rs) begin
            mvalid[m] = 1'b0;
            mseed[m]  = sd;
            mcnt[m]   = 0;
        end else if (!mvalid[m]) begin
            mcnt[m]++;
            if (mcnt[m] == nl[m] + 1 + wu[m]) begin
                mseedlanes(m);
                repeat (wu[m] + 1) mstep(m);
                mvalid[m] = 1'b1;
            end
        end else if (rdy) begin
            mstep(m);
        end
    endtask

    task automatic check_dut(input int m, input logic v, input logic b, input logic [511:0] d);
        int bad;
        bit dup;
        if (!mstarted[m]) return;
        expect32($sformatf("valid%0d", m), 32'(v), 32'(mvalid[m]));
        expect32($sformatf("busy%0d", m), 32'(b), 32'(!mvalid[m]));
        if (mvalid[m]) begin
            bad = -1;
            for (int l = 0; l < nl[m]; l++)
                if (bad < 0 && d[32*l +: 32] !== mword(m, l)) bad = l;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL data%0d lane %0d: got %h expected %h", m, bad, d[32*bad +: 32], mword(m, bad));
            end
        end
        if (m == 1 && distinct_en && mvalid[m]) begin
            dup = 1'b0;
            for (int i = 0; i < 16; i++)
                for (int j = i + 1; j < 16; j++)
                    if (d[32*i +: 32] == d[32*j +: 32]) dup = 1'b1;
            checks++;
            if (dup) begin
                errors++;
                $display("FAIL distinct1: got duplicated lane words expected all 16 distinct");
            end
        end
    endtask

    always @(posedge clk) begin
        medge(0, rstA, reseedA, seedA, rdyA);
        medge(1, rstB, reseedB, seedB, rdyB);
    end

    always @(negedge clk) begin
        check_dut(0, validA, busyA, 512'(dataA));
        check_dut(1, validB, busyB, dataB);
    end

    task automatic wait_valid(input int m, input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            @(negedge clk);
            cyc++;
            if ((m == 0 ? validA : validB) === 1'b1) return;
        end
        cyc = limit + 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int cyc, n, hs, i;
        rstA = 1'b1; reseedA = 1'b0; seedA = '0; rdyA = 1'b1;
        rstB = 1'b1; reseedB = 1'b0; seedB = '0; rdyB = 1'b0;
        repeat (3) @(negedge clk);
        expect32("rstA_data", dataA[31:0], 32'h0);
        expect32("rstA_valid", 32'(validA), 32'd0);
        expect32("rstA_busy", 32'(busyA), 32'd1);
        expect32("rstB_data", dataB[511:480], 32'h0);
        expect32("rstB_busy", 32'(busyB), 32'd1);

        // Reset release: latency and first two lane-0 words for seed 0
        rstA = 1'b0; rstB = 1'b0;
        wait_valid(0, 20, cyc);
        expect32("A_latency", 32'(cyc), 32'd5);
        expect32("A_word1", dataA[31:0], 32'h0020_2080);
        expect32("model_word1", mword(0, 0), 32'h0020_2080);
        @(negedge clk);
        expect32("A_word2", dataA[31:0], 32'h0200_2C80);
        expect32("model_word2", mword(0, 0), 32'h0200_2C80);
        repeat (6) @(negedge clk);

        // Backpressure: long stall, then a mixed ready pattern
        rdyA = 1'b0;
        repeat (10) @(negedge clk);
        rdyA = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 24; k++) begin
            rdyA = (k % 3 != 1);
            @(negedge clk);
        end
        rdyA = 1'b1;

        // Mid-RUN reseed coinciding with a handshake
        seedA = 32'h0; reseedA = 1'b1;
        @(negedge clk);
        reseedA = 1'b0; seedA = 32'hFFFF_FFFF;
        expect32("A_reseed_valid", 32'(validA), 32'd0);
        n = 0;
        while (busyA && n < 20) begin
            n++;
            @(negedge clk);
        end
        expect32("A_busy_len", 32'(n), 32'd5);
        expect32("A_restart_word", dataA[31:0], 32'h0020_2080);
        repeat (5) @(negedge clk);

        // Reseed while seeding lane 2
        reseedA = 1'b1; seedA = 32'hCAFE_F00D;
        @(negedge clk);
        reseedA = 1'b0; seedA = 32'h0;
        repeat (2) @(negedge clk);
        reseedA = 1'b1; seedA = 32'h0BAD_F00D;
        @(negedge clk);
        reseedA = 1'b0;
        wait_valid(0, 20, cyc);
        expect32("A_latency_restart", 32'(cyc), 32'd5);
        for (int k = 0; k < 20; k++) begin
            rdyA = (k % 4 != 2);
            @(negedge clk);
        end
        rdyA = 1'b1;

        // rst beats reseed: default seed 0 is used, not the offered seed
        rstA = 1'b1; reseedA = 1'b1; seedA = 32'hFFFF_FFFF;
        @(negedge clk);
        rstA = 1'b0; reseedA = 1'b0;
        wait_valid(0, 20, cyc);
        expect32("A_latency_rst", 32'(cyc), 32'd5);
        expect32("A_rst_prio_word", dataA[31:0], 32'h0020_2080);

        // B: drain a few words from the default seed
        rdyB = 1'b1;
        repeat (5) @(negedge clk);

        // WARMUP=8, seed 0: valid after 16+9 cycles
        seedB = 32'h0; reseedB = 1'b1;
        @(negedge clk);
        reseedB = 1'b0;
        wait_valid(1, 60, cyc);
        expect32("B_latency", 32'(cyc), 32'd25);
        repeat (5) @(negedge clk);

        // Reseed during WARM
        reseedB = 1'b1; seedB = 32'h0;
        @(negedge clk);
        reseedB = 1'b0;
        repeat (19) @(negedge clk);
        reseedB = 1'b1; seedB = 32'h1357_9BDF;
        @(negedge clk);
        reseedB = 1'b0;
        wait_valid(1, 60, cyc);
        expect32("B_latency_warm", 32'(cyc), 32'd25);

        // 1000 words from seed DEADBEEF on 16 lanes with occasional stalls
        seedB = 32'hDEAD_BEEF; reseedB = 1'b1;
        @(negedge clk);
        reseedB = 1'b0;
        wait_valid(1, 60, cyc);
        expect32("B_latency_dead", 32'(cyc), 32'd25);
        distinct_en = 1'b1;
        hs = 0;
        i = 0;
        while (hs < 1000 && i < 3000) begin
            rdyB = (i % 7 != 3);
            if (validB && rdyB) hs++;
            @(negedge clk);
            i++;
        end
        expect32("B_words", 32'(hs), 32'd1000);
        distinct_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
